// File: rtl/decode_stage.sv
// Registered MIPS-I instruction decode stage with valid/ready handshake, flush,
// load-use stall detection, illegal-instruction flagging and a saturating stall counter.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int ALUCODE_W = 5,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_valid_i,
  input  logic [31:0]          if_instr_i,
  input  logic [XLEN-1:0]      if_pc_i,
  output logic                 if_ready_o,
  input  logic                 flush_i,
  input  logic                 ex_ready_i,
  output logic                 id_valid_o,
  output logic [XLEN-1:0]      id_pc_o,
  output logic [ALUCODE_W-1:0] id_alucode_o,
  output logic [9:0]           id_ctrl_o,
  output logic [4:0]           id_rs_o,
  output logic [4:0]           id_rt_o,
  output logic [4:0]           id_rd_o,
  output logic [4:0]           id_shamt_o,
  output logic [XLEN-1:0]      id_imm_o,
  output logic                 id_illegal_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  localparam logic [ALUCODE_W-1:0] ALU_ADD  = ALUCODE_W'(5'b00000);
  localparam logic [ALUCODE_W-1:0] ALU_AND  = ALUCODE_W'(5'b00001);
  localparam logic [ALUCODE_W-1:0] ALU_XOR  = ALUCODE_W'(5'b00010);
  localparam logic [ALUCODE_W-1:0] ALU_OR   = ALUCODE_W'(5'b00011);
  localparam logic [ALUCODE_W-1:0] ALU_NOR  = ALUCODE_W'(5'b00100);
  localparam logic [ALUCODE_W-1:0] ALU_SUB  = ALUCODE_W'(5'b00101);
  localparam logic [ALUCODE_W-1:0] ALU_ANDI = ALUCODE_W'(5'b00110);
  localparam logic [ALUCODE_W-1:0] ALU_XORI = ALUCODE_W'(5'b00111);
  localparam logic [ALUCODE_W-1:0] ALU_ORI  = ALUCODE_W'(5'b01000);
  localparam logic [ALUCODE_W-1:0] ALU_JR   = ALUCODE_W'(5'b01001);
  localparam logic [ALUCODE_W-1:0] ALU_BEQ  = ALUCODE_W'(5'b01010);
  localparam logic [ALUCODE_W-1:0] ALU_BNE  = ALUCODE_W'(5'b01011);
  localparam logic [ALUCODE_W-1:0] ALU_BGEZ = ALUCODE_W'(5'b01100);
  localparam logic [ALUCODE_W-1:0] ALU_BGTZ = ALUCODE_W'(5'b01101);
  localparam logic [ALUCODE_W-1:0] ALU_BLEZ = ALUCODE_W'(5'b01110);
  localparam logic [ALUCODE_W-1:0] ALU_BLTZ = ALUCODE_W'(5'b01111);
  localparam logic [ALUCODE_W-1:0] ALU_SLL  = ALUCODE_W'(5'b10000);
  localparam logic [ALUCODE_W-1:0] ALU_SRL  = ALUCODE_W'(5'b10001);
  localparam logic [ALUCODE_W-1:0] ALU_SRA  = ALUCODE_W'(5'b10010);
  localparam logic [ALUCODE_W-1:0] ALU_SLT  = ALUCODE_W'(5'b10011);
  localparam logic [ALUCODE_W-1:0] ALU_SLTU = ALUCODE_W'(5'b10100);
  localparam logic [ALUCODE_W-1:0] ALU_ADDU = ALUCODE_W'(5'b10101);
  localparam logic [ALUCODE_W-1:0] ALU_SUBU = ALUCODE_W'(5'b10110);

  localparam int C_REGWRITE = 9;
  localparam int C_REGDST   = 8;
  localparam int C_MEMWRITE = 7;
  localparam int C_MEMREAD  = 6;
  localparam int C_MEMTOREG = 5;
  localparam int C_ALUSRCA  = 4;
  localparam int C_ALUSRCB  = 3;
  localparam int C_J        = 2;
  localparam int C_JR       = 1;
  localparam int C_BRANCH   = 0;

  logic [5:0]  op;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [4:0]  f_shamt;
  logic [5:0]  f_funct;
  logic [15:0] f_imm;

  assign op      = if_instr_i[31:26];
  assign f_rs    = if_instr_i[25:21];
  assign f_rt    = if_instr_i[20:16];
  assign f_rd    = if_instr_i[15:11];
  assign f_shamt = if_instr_i[10:6];
  assign f_funct = if_instr_i[5:0];
  assign f_imm   = if_instr_i[15:0];

  logic [9:0]           dec_ctrl;
  logic [ALUCODE_W-1:0] dec_alu;
  logic                 dec_ill;
  logic                 dec_zext;
  logic                 reads_rs;
  logic                 reads_rt;
  logic                 r_shift;
  logic                 r_arith;

  always_comb begin
    dec_ctrl = '0;
    dec_alu  = ALU_ADD;
    dec_ill  = 1'b0;
    dec_zext = 1'b0;
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    r_shift  = 1'b0;
    r_arith  = 1'b0;
    case (op)
      6'b000000: begin
        reads_rt = 1'b1;
        // The all-zero word is the canonical NOP, not an SLL r0,r0,0.
        if (if_instr_i != 32'd0) begin
          case (f_funct)
            6'b000000: begin r_shift = 1'b1; dec_alu = ALU_SLL;  end
            6'b000010: begin r_shift = 1'b1; dec_alu = ALU_SRL;  end
            6'b000011: begin r_shift = 1'b1; dec_alu = ALU_SRA;  end
            6'b100000: begin r_arith = 1'b1; dec_alu = ALU_ADD;  end
            6'b100001: begin r_arith = 1'b1; dec_alu = ALU_ADDU; end
            6'b100010: begin r_arith = 1'b1; dec_alu = ALU_SUB;  end
            6'b100011: begin r_arith = 1'b1; dec_alu = ALU_SUBU; end
            6'b100100: begin r_arith = 1'b1; dec_alu = ALU_AND;  end
            6'b100101: begin r_arith = 1'b1; dec_alu = ALU_OR;   end
            6'b100110: begin r_arith = 1'b1; dec_alu = ALU_XOR;  end
            6'b100111: begin r_arith = 1'b1; dec_alu = ALU_NOR;  end
            6'b101010: begin r_arith = 1'b1; dec_alu = ALU_SLT;  end
            6'b101011: begin r_arith = 1'b1; dec_alu = ALU_SLTU; end
            6'b001000: begin
              reads_rs       = 1'b1;
              dec_alu        = ALU_JR;
              dec_ctrl[C_JR] = 1'b1;
            end
            default: dec_ill = 1'b1;
          endcase
          if (r_shift || r_arith) begin
            dec_ctrl[C_REGWRITE] = 1'b1;
            dec_ctrl[C_REGDST]   = 1'b1;
            dec_ctrl[C_ALUSRCA]  = r_shift;
            reads_rs             = r_arith;
          end
        end
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110: begin
        reads_rs             = 1'b1;
        dec_ctrl[C_REGWRITE] = 1'b1;
        dec_ctrl[C_ALUSRCB]  = 1'b1;
        case (op)
          6'b001001: dec_alu = ALU_ADDU;
          6'b001010: dec_alu = ALU_SLT;
          6'b001011: dec_alu = ALU_SLTU;
          6'b001100: begin dec_alu = ALU_ANDI; dec_zext = 1'b1; end
          6'b001101: begin dec_alu = ALU_ORI;  dec_zext = 1'b1; end
          6'b001110: begin dec_alu = ALU_XORI; dec_zext = 1'b1; end
          default:   dec_alu = ALU_ADD;
        endcase
      end
      6'b100011: begin
        reads_rs             = 1'b1;
        dec_ctrl[C_REGWRITE] = 1'b1;
        dec_ctrl[C_MEMREAD]  = 1'b1;
        dec_ctrl[C_MEMTOREG] = 1'b1;
        dec_ctrl[C_ALUSRCB]  = 1'b1;
      end
      6'b101011: begin
        reads_rs             = 1'b1;
        reads_rt             = 1'b1;
        dec_ctrl[C_MEMWRITE] = 1'b1;
        dec_ctrl[C_ALUSRCB]  = 1'b1;
      end
      6'b000100, 6'b000101: begin
        reads_rs           = 1'b1;
        reads_rt           = 1'b1;
        dec_ctrl[C_BRANCH] = 1'b1;
        dec_alu            = (op == 6'b000100) ? ALU_BEQ : ALU_BNE;
      end
      6'b000110, 6'b000111: begin
        reads_rs = 1'b1;
        if (f_rt != 5'd0) begin
          dec_ill = 1'b1;
        end else begin
          dec_ctrl[C_BRANCH] = 1'b1;
          dec_alu            = (op == 6'b000110) ? ALU_BLEZ : ALU_BGTZ;
        end
      end
      6'b000001: begin
        reads_rs = 1'b1;
        if (f_rt == 5'b00001) begin
          dec_ctrl[C_BRANCH] = 1'b1;
          dec_alu            = ALU_BGEZ;
        end else if (f_rt == 5'b00000) begin
          dec_ctrl[C_BRANCH] = 1'b1;
          dec_alu            = ALU_BLTZ;
        end else begin
          dec_ill = 1'b1;
        end
      end
      6'b000010: dec_ctrl[C_J] = 1'b1;
      default:   dec_ill = 1'b1;
    endcase
    // An undecodable word travels on as an inert no-op.
    if (dec_ill) begin
      dec_ctrl = '0;
      dec_alu  = ALU_ADD;
      reads_rs = 1'b0;
      reads_rt = 1'b0;
    end
  end

  logic [XLEN-1:0] dec_imm;
  assign dec_imm = dec_zext ? {{(XLEN-16){1'b0}}, f_imm}
                            : {{(XLEN-16){f_imm[15]}}, f_imm};

  logic                 id_valid_q,   id_valid_d;
  logic [XLEN-1:0]      id_pc_q;
  logic [ALUCODE_W-1:0] id_alucode_q;
  logic [9:0]           id_ctrl_q;
  logic [4:0]           id_rs_q;
  logic [4:0]           id_rt_q;
  logic [4:0]           id_rd_q;
  logic [4:0]           id_shamt_q;
  logic [XLEN-1:0]      id_imm_q;
  logic                 id_illegal_q;
  logic [CNT_W-1:0]     stall_cnt_q,  stall_cnt_d;

  logic hazard;
  logic accept;

  // A load in ID cannot forward to the instruction right behind it.
  assign hazard = (HAZARD_EN != 0) && id_valid_q && id_ctrl_q[C_MEMREAD] &&
                  (id_rt_q != 5'd0) && if_valid_i &&
                  ((reads_rs && (f_rs == id_rt_q)) || (reads_rt && (f_rt == id_rt_q)));

  assign if_ready_o = (~id_valid_q | ex_ready_i) & ~hazard & ~flush_i;
  assign accept     = if_valid_i & if_ready_o;

  always_comb begin
    id_valid_d  = id_valid_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      id_valid_d = 1'b0;
    end else if (hazard && ex_ready_i) begin
      id_valid_d = 1'b0;
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else if (accept) begin
      id_valid_d = 1'b1;
    end else if (ex_ready_i) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_alucode_q <= '0;
      id_ctrl_q    <= '0;
      id_rs_q      <= '0;
      id_rt_q      <= '0;
      id_rd_q      <= '0;
      id_shamt_q   <= '0;
      id_imm_q     <= '0;
      id_illegal_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (accept) begin
        id_pc_q      <= if_pc_i;
        id_alucode_q <= dec_alu;
        id_ctrl_q    <= dec_ctrl;
        id_rs_q      <= f_rs;
        id_rt_q      <= f_rt;
        id_rd_q      <= f_rd;
        id_shamt_q   <= f_shamt;
        id_imm_q     <= dec_imm;
        id_illegal_q <= dec_ill;
      end
    end
  end

  assign id_valid_o   = id_valid_q;
  assign id_pc_o      = id_pc_q;
  assign id_alucode_o = id_alucode_q;
  assign id_ctrl_o    = id_ctrl_q;
  assign id_rs_o      = id_rs_q;
  assign id_rt_o      = id_rt_q;
  assign id_rd_o      = id_rd_q;
  assign id_shamt_o   = id_shamt_q;
  assign id_imm_o     = id_imm_q;
  assign id_illegal_o = id_illegal_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
